// File: rtl/uart_wb_tx_master_if.sv
// Byte stream and Wishbone master signal bundle for uart_wb_tx_master.
// The master modport is the block's side; slave is the UART/stream peer.
interface uart_wb_tx_master_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [4:0] wb_addr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic [3:0] wb_sel_o;
  logic       wb_we_o;
  logic       wb_stb_o;
  logic       wb_cyc_o;
  logic       wb_ack_i;

  modport master (
    input  s_data, s_valid, wb_dat_i, wb_ack_i,
    output s_ready, wb_addr_o, wb_dat_o, wb_sel_o,
    output wb_we_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output s_data, s_valid, wb_dat_i, wb_ack_i,
    input  s_ready, wb_addr_o, wb_dat_o, wb_sel_o,
    input  wb_we_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/uart_wb_tx_master.sv
// Wishbone master that configures a 16550 UART and feeds its THR from a
// valid/ready byte stream, throttled by LSR.THRE polling.
module uart_wb_tx_master #(
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  uart_wb_tx_master_if.master bus,
  output logic init_done,
  output logic timeout_err
);

  typedef enum logic [3:0] {
    INIT0, INIT1, INIT2, INIT3, INIT4,
    IDLE, RD_LSR, WR_THR, ERR
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       act_q, act_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] dat_q, dat_d;
  logic       we_q, we_d;
  logic [7:0] cnt_q, cnt_d;
  logic       hold_q, hold_d;
  logic [7:0] byte_q, byte_d;
  logic [4:0] credit_q, credit_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       req;
  logic       req_we;
  logic [4:0] req_addr;
  logic [7:0] req_dat;
  state_t     ack_state;
  logic       drop;
  logic       s_ready;

  logic unused_dat;
  assign unused_dat = ^{bus.wb_dat_i[7:6], bus.wb_dat_i[4:0]};

  assign s_ready = done_q & ~hold_q & ~err_q;

  always_comb begin
    req       = 1'b0;
    req_we    = 1'b1;
    req_addr  = 5'd0;
    req_dat   = 8'h00;
    ack_state = IDLE;
    state_d   = state_q;
    act_d     = act_q;
    addr_d    = addr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    byte_d    = byte_q;
    credit_d  = credit_q;
    done_d    = done_q;
    err_d     = err_q;
    drop      = 1'b0;

    unique case (state_q)
      INIT0: begin
        req       = 1'b1;
        req_addr  = 5'd3;
        req_dat   = LCR_VAL | 8'h80;
        ack_state = INIT1;
      end
      INIT1: begin
        req       = 1'b1;
        req_addr  = 5'd0;
        req_dat   = DIVISOR[7:0];
        ack_state = INIT2;
      end
      INIT2: begin
        req       = 1'b1;
        req_addr  = 5'd1;
        req_dat   = DIVISOR[15:8];
        ack_state = INIT3;
      end
      INIT3: begin
        req       = 1'b1;
        req_addr  = 5'd3;
        req_dat   = LCR_VAL & 8'h7F;
        ack_state = INIT4;
      end
      INIT4: begin
        req       = 1'b1;
        req_addr  = 5'd2;
        req_dat   = 8'h07;
        ack_state = IDLE;
      end
      IDLE: begin
        if (hold_q) begin
          state_d = (credit_q != 5'd0) ? WR_THR : RD_LSR;
        end
      end
      RD_LSR: begin
        req      = 1'b1;
        req_we   = 1'b0;
        req_addr = 5'd5;
      end
      WR_THR: begin
        req      = 1'b1;
        req_addr = 5'd0;
        req_dat  = byte_q;
      end
      ERR: ;
      default: state_d = ERR;
    endcase

    if (bus.s_valid && s_ready) begin
      hold_d = 1'b1;
      byte_d = bus.s_data;
    end

    // Issue on the first cycle in a bus state; ack wins over timeout.
    if (req) begin
      if (!act_q) begin
        act_d  = 1'b1;
        addr_d = req_addr;
        dat_d  = req_we ? req_dat : 8'h00;
        we_d   = req_we;
        cnt_d  = 8'd0;
      end else if (bus.wb_ack_i) begin
        drop    = 1'b1;
        state_d = ack_state;
        if (state_q == INIT4) done_d = 1'b1;
        if (state_q == RD_LSR && bus.wb_dat_i[5]) begin
          credit_d = 5'd16;
        end
        if (state_q == WR_THR) begin
          hold_d   = 1'b0;
          credit_d = credit_q - 5'd1;
        end
      end else if (cnt_q == TO_LAST) begin
        drop    = 1'b1;
        state_d = ERR;
        err_d   = 1'b1;
        hold_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    if (drop) begin
      act_d  = 1'b0;
      addr_d = 5'd0;
      dat_d  = 8'h00;
      we_d   = 1'b0;
      cnt_d  = 8'd0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= INIT0;
      act_q    <= 1'b0;
      addr_q   <= 5'd0;
      dat_q    <= 8'h00;
      we_q     <= 1'b0;
      cnt_q    <= 8'd0;
      hold_q   <= 1'b0;
      byte_q   <= 8'h00;
      credit_q <= 5'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      addr_q   <= addr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      byte_q   <= byte_d;
      credit_q <= credit_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.wb_cyc_o  = act_q;
  assign bus.wb_stb_o  = act_q;
  assign bus.wb_sel_o  = {3'b000, act_q};
  assign bus.wb_addr_o = addr_q;
  assign bus.wb_dat_o  = dat_q;
  assign bus.wb_we_o   = we_q;
  assign init_done     = done_q;
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_uart_wb_tx_master.sv
// Scoreboard bench: a credit/LSR reference model predicts the Wishbone
// transaction stream; a negedge monitor pops and compares each ack.
module tb_uart_wb_tx_master;

  localparam logic [15:0] DIV = 16'h0145;
  localparam logic [7:0]  LCR = 8'h1B;
  localparam int          TO  = 8;

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [7:0] dat;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init_done;
  logic timeout_err;

  uart_wb_tx_master_if bus();

  uart_wb_tx_master #(
    .DIVISOR(DIV),
    .LCR_VAL(LCR),
    .ACK_TIMEOUT(TO)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus.master),
    .init_done(init_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  txn_t       exp_q[$];
  logic [7:0] lsr_slv[$];
  logic [7:0] lsr_mdl[$];
  int         m_credits = 0;
  int         maxw = 0;
  bit         no_ack_thr = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: credits refilled to 16 by an LSR read with THRE set.
  task automatic model_byte(input logic [7:0] b, input bit wr);
    logic [7:0] v;
    while (m_credits == 0) begin
      exp_q.push_back('{we: 1'b0, addr: 5'd5, dat: 8'h00});
      v = (lsr_mdl.size() != 0) ? lsr_mdl.pop_front() : 8'h60;
      if (v[5]) m_credits = 16;
    end
    if (wr) begin
      exp_q.push_back('{we: 1'b1, addr: 5'd0, dat: b});
      m_credits--;
    end
  endtask

  task automatic push_init();
    exp_q.push_back('{1'b1, 5'd3, LCR | 8'h80});
    exp_q.push_back('{1'b1, 5'd0, DIV[7:0]});
    exp_q.push_back('{1'b1, 5'd1, DIV[15:8]});
    exp_q.push_back('{1'b1, 5'd3, LCR & 8'h7F});
    exp_q.push_back('{1'b1, 5'd2, 8'h07});
  endtask

  task automatic add_lsr(input logic [7:0] v);
    lsr_slv.push_back(v);
    lsr_mdl.push_back(v);
  endtask

  // Slave: random wait states, LSR replies from a scripted queue.
  initial begin
    int wc;
    wc = -1;
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst || bus.wb_ack_i) begin
        bus.wb_ack_i = 1'b0;
        bus.wb_dat_i = 8'h00;
        if (rst) wc = -1;
      end else if (bus.wb_stb_o) begin
        if (!(no_ack_thr && bus.wb_we_o &&
              bus.wb_addr_o == 5'd0 && init_done)) begin
          if (wc < 0) wc = $urandom_range(0, maxw);
          if (wc == 0) begin
            bus.wb_ack_i = 1'b1;
            wc = -1;
            if (!bus.wb_we_o) begin
              bus.wb_dat_i = (lsr_slv.size() != 0) ?
                             lsr_slv.pop_front() : 8'h60;
            end
          end else begin
            wc--;
          end
        end
      end
    end
  end

  // Monitor
  initial begin
    bit   p_ack, p_thr, p_fcr;
    txn_t got, e;
    p_ack = 0; p_thr = 0; p_fcr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_ack = 0; p_thr = 0; p_fcr = 0;
      end else begin
        if (p_ack) chk("idle_gap", int'(bus.wb_cyc_o), 0);
        if (p_thr) chk("s_ready_after_thr_ack", int'(bus.s_ready), 1);
        if (p_fcr) chk("init_done_after_fcr", int'(init_done), 1);
        p_ack = bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i;
        p_thr = p_ack && bus.wb_we_o && bus.wb_addr_o == 5'd0 && init_done;
        p_fcr = p_ack && bus.wb_we_o && bus.wb_addr_o == 5'd2;
        if (p_fcr) chk("init_done_before_fcr", int'(init_done), 0);
        if (p_ack) begin
          got = {bus.wb_we_o, bus.wb_addr_o, bus.wb_dat_o};
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_txn actual=%0h required=none",
                     got);
          end else begin
            e = exp_q.pop_front();
            chk("bus_txn", int'(got), int'(e));
          end
          chk("sel", int'(bus.wb_sel_o), 1);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.s_valid = 1'b0;
    exp_q.delete();
    lsr_slv.delete();
    lsr_mdl.delete();
    m_credits = 0;
    no_ack_thr = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        int'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o,
              bus.wb_addr_o, bus.wb_dat_o, bus.s_ready,
              init_done, timeout_err}), 0);
    rst = 1'b0;
    push_init();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit wr);
    int   n;
    logic r;
    n = 0;
    @(negedge clk);
    bus.s_data  = b;
    bus.s_valid = 1'b1;
    while (1) begin
      r = bus.s_ready;
      @(posedge clk);
      if (r) begin
        model_byte(b, wr);
        break;
      end
      n++;
      if (n > 2000) begin
        chk("send_accept", 0, 1);
        break;
      end
      @(negedge clk);
    end
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.wb_cyc_o) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic wait_thr_stb();
    int n;
    n = 0;
    while (!(bus.wb_stb_o && bus.wb_we_o && init_done) && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int cnt;
    int bad;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    maxw = 0;
    do_reset();
    add_lsr(8'h60);
    send_byte(8'hA5, 1);
    drain(300);

    do_reset();
    for (int i = 0; i < 17; i++) send_byte(8'($urandom), 1);
    drain(2000);

    do_reset();
    add_lsr(8'h00);
    add_lsr(8'h00);
    add_lsr(8'h00);
    add_lsr(8'h20);
    send_byte(8'h3C, 1);
    drain(500);

    do_reset();
    maxw = 3;
    for (int i = 0; i < 40; i++) add_lsr(8'($urandom));
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(8'($urandom), 1);
    end
    drain(5000);

    maxw = 0;
    do_reset();
    no_ack_thr = 1;
    send_byte(8'h5A, 0);
    wait_thr_stb();
    cnt = 0;
    while (bus.wb_stb_o && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    chk("stb_width_timeout", cnt, TO);
    chk("timeout_err", int'(timeout_err), 1);
    bus.s_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.s_ready || !timeout_err || bus.wb_cyc_o) bad++;
    end
    bus.s_valid = 1'b0;
    chk("err_sticky", bad, 0);
    chk("timeout_pending", exp_q.size(), 0);

    do_reset();
    no_ack_thr = 1;
    send_byte(8'hC3, 0);
    wait_thr_stb();
    chk("thr_stb_seen", int'(bus.wb_stb_o), 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset",
        int'({bus.wb_cyc_o, bus.wb_stb_o, bus.s_ready, init_done}), 0);
    do_reset();
    send_byte(8'h81, 1);
    drain(500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_wb_tx_master.md
# uart_wb_tx_master

Wishbone bus master that sits directly upstream of the UART 16550 core's Wishbone slave port. After reset it programs the core's line control, divisor and FIFO control registers. It then converts a valid/ready byte stream into THR writes, gated by LSR.THRE polling so the 16-byte transmit FIFO never overflows. It gives the design a hardware-only transmit path with no CPU involvement.

## Interface

Parameters:
- `DIVISOR`, default 16'd27: baud divisor written to DLL/DLM.
- `LCR_VAL`, default 8'h03: line control value (8N1); bit 7 is ignored and forced by the block.
- `ACK_TIMEOUT`, default 255: maximum cycles to wait for `wb_ack_i`, range 1..255.

Ports:
- `wb_clk_i`, in, 1: the only clock.
- `wb_rst_i`, in, 1: reset, **asynchronous and active-high**.
- `s_data`, in, 8: byte to transmit.
- `s_valid`, in, 1: `s_data` is valid.
- `s_ready`, out, 1: the block accepts `s_data` this cycle.
- `wb_addr_o`, out, 5: Wishbone address (register index 0..7).
- `wb_dat_o`, out, 8: write data.
- `wb_dat_i`, in, 8: read data.
- `wb_sel_o`, out, 4: byte select.
- `wb_we_o`, out, 1: write enable.
- `wb_stb_o`, out, 1: strobe.
- `wb_cyc_o`, out, 1: cycle.
- `wb_ack_i`, in, 1: slave acknowledge.
- `init_done`, out, 1: configuration is complete; sticky until reset.
- `timeout_err`, out, 1: an ack timeout occurred; sticky until reset.

## Operation

- **Reset:** all outputs are 0. The holding register is empty, the credit counter is 0 and the FSM is in INIT0.
- **Init sequence:** a fixed series of writes, in order.
  - INIT0: addr 3 ← `LCR_VAL | 8'h80` (DLAB set).
  - INIT1: addr 0 ← `DIVISOR[7:0]`.
  - INIT2: addr 1 ← `DIVISOR[15:8]`.
  - INIT3: addr 3 ← `LCR_VAL & 8'h7F`.
  - INIT4: addr 2 ← 8'h07 (FCR: enable FIFOs and clear both).
  - On the INIT4 ack, `init_done` is set and the FSM enters IDLE.
- **Input holding register:** one entry.
  - `s_ready = init_done & ~hold_valid & ~timeout_err`.
  - On `s_valid & s_ready`, the byte is captured and `hold_valid` is set.
- **Credit counter:** 5 bits, range 0..16. It counts THR writes still known to be safe.
- **IDLE:**
  - If `hold_valid` and credits > 0, go to WR_THR.
  - Else if `hold_valid`, go to RD_LSR.
  - Else stay in IDLE.
- **RD_LSR:** read addr 5.
  - On ack with `wb_dat_i[5]=1`, credits ← 16.
  - If `wb_dat_i[5]=0`, credits are unchanged (0).
  - Return to IDLE. The re-poll happens after the mandatory idle cycle.
- **WR_THR:** write addr 0 ← held byte.
  - On ack, clear `hold_valid` and decrement credits.
  - Return to IDLE.
- **ERR:** entered from any bus state on timeout.
  - Drive `cyc`/`stb` low and set `timeout_err`.
  - `s_ready` is 0. The block stays in ERR until reset. The held byte is discarded.
- **Simultaneous events:** capture into an empty holding register and clearing of a held byte cannot coincide, because `s_ready` is low while `hold_valid` is set. The freed slot is offered starting the cycle after the WR_THR ack.

## Timing

- **Bus transactions:** `wb_cyc_o`, `wb_stb_o`, `wb_addr_o`, `wb_dat_o`, `wb_we_o` and `wb_sel_o` are registered.
  - They assert on the cycle after entry to a bus state.
  - They are held constant until the edge where `wb_ack_i=1` is sampled.
  - They deassert on the following cycle.
  - `wb_sel_o` is 4'b0001 while `stb` is high, otherwise 4'b0000.
  - `wb_we_o` is 0 during RD_LSR.
  - `wb_dat_o` is 0 when not writing.
- **Idle gap:** at least one idle cycle (`cyc`=0) between consecutive transactions.
- **Read data:** `wb_dat_i` is sampled only on the ack edge.
- **Timeout:** a counter starts at 0 when `stb` rises.
  - If it reaches `ACK_TIMEOUT` without an ack, the cycle is aborted on the next edge.
  - An ack arriving on the same edge the count hits `ACK_TIMEOUT` counts as success.
- **Best-case latency:** with a zero-wait-state slave (ack one cycle after `stb`), a captured byte with credits available reaches THR in 3 cycles: IDLE → WR_THR → ack.
- **Stream throughput:** one byte per 4 cycles, given capture, write, ack and gap.
- **`init_done`:** rises the cycle after the INIT4 ack.
- **Reset mid-transaction:** `cyc`/`stb` drop immediately (asynchronously), and init restarts from INIT0 after reset deasserts.

## Test plan

- **Init sequence:** reset, zero-wait slave, `DIVISOR`=16'h0145, `LCR_VAL`=8'h1B.
  - Required writes, in order: (3,8'h9B), (0,8'h45), (1,8'h01), (3,8'h1B), (2,8'h07).
  - `init_done`=1 one cycle after the fifth ack.
- **Single byte:** send 8'hA5 with the LSR model returning 8'h60.
  - Required: one LSR read, then a THR write of 8'hA5.
  - `s_ready` returns high the cycle after the THR ack.
- **Burst of 17:** LSR always returns 8'h60, 17 bytes sent back-to-back.
  - Required: read LSR, 16 THR writes, read LSR, 1 THR write.
  - Byte order is preserved.
- **Full FIFO polling:** LSR returns 8'h00 three times, then 8'h20.
  - Required: four LSR reads, each separated by at least 1 idle cycle, then the THR write.
  - No THR write may occur before THRE=1.
- **Ack timeout:** `ACK_TIMEOUT`=8, slave never acks the THR write.
  - Required: `stb` is high for exactly 8 cycles, then drops.
  - `timeout_err`=1 and `s_ready`=0 persist until reset.
- **Reset mid-transfer:** assert `wb_rst_i` while `stb`=1 during WR_THR.
  - Required: `cyc`/`stb`/`s_ready`/`init_done` go to 0 without waiting for a clock edge.
  - After release, INIT0 writes (3, `LCR_VAL|8'h80`) first.
